// File: rtl/game2048_pkg.sv
`default_nettype none
// game2048_pkg: shared tile width, direction codes, FSM state encoding and board index helpers.
// Rev 1.0
package game2048_pkg;

  localparam int TILE_W  = 11;
  localparam int WIN_BIT = TILE_W - 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] LAST_LANE = 2'd3;
  localparam logic [3:0] LAST_CELL = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LANE  = 3'd1,
    ST_GAP   = 3'd2,
    ST_SPAWN = 3'd3,
    ST_CHECK = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_t;

  function automatic logic [1:0] cell_row(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] cell_col(input logic [3:0] idx);
    return idx[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_sequencer_2048_if.sv
`default_nettype none
// move_sequencer_2048_if: lane-slide handshake plus board RAM read/write ports.
// Rev 1.0
interface move_sequencer_2048_if #(
  parameter int TILE_W = game2048_pkg::TILE_W
);
  logic              lane_req;
  logic [1:0]        lane_dir;
  logic [1:0]        lane_idx;
  logic              lane_ack;
  logic              lane_moved;
  logic [3:0]        cell_rd_addr;
  logic [TILE_W-1:0] cell_rd_data;
  logic              cell_wr_en;
  logic [3:0]        cell_wr_addr;
  logic [TILE_W-1:0] cell_wr_data;

  modport master (
    output lane_req, lane_dir, lane_idx,
    input  lane_ack, lane_moved,
    output cell_rd_addr,
    input  cell_rd_data,
    output cell_wr_en, cell_wr_addr, cell_wr_data
  );

  modport slave (
    input  lane_req, lane_dir, lane_idx,
    output lane_ack, lane_moved,
    input  cell_rd_addr,
    output cell_rd_data,
    input  cell_wr_en, cell_wr_addr, cell_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running every cycle.
// Rev 1.0
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] state
);
  logic [15:0] r_state;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= SEED;
    else       r_state <= {r_state[14:0], r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10]};
  end

  assign state = r_state;
endmodule
`default_nettype wire

// File: rtl/move_sequencer_2048.sv
`default_nettype none
// move_sequencer_2048: runs one move (4 lane slides, random tile spawn, win/lose scan).
// Rev 1.0 -- define PRESS_QUEUE_EN to keep one press that arrives while busy.
module move_sequencer_2048
  import game2048_pkg::*;
#(
  parameter int          TILE_W    = game2048_pkg::TILE_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  move_sequencer_2048_if.master lane_bus,
  output logic                  busy,
  output logic                  game_won,
  output logic                  game_lost
);
  state_t            r_state, w_state_nxt;
  logic [15:0]       w_lfsr;
  logic              w_unused_lfsr;
  logic [3:0]        w_btn, r_btn_prev, w_rise;
  logic              w_press, w_launch;
  logic [1:0]        w_press_dir, w_launch_dir;
  logic [1:0]        r_dir, r_idx;
  logic              r_moved_any;
  logic [3:0]        r_scan_addr, r_scan_cnt, r_chk_idx;
  logic              r_win, r_open;
  logic [TILE_W-1:0] r_row [4];
  logic [TILE_W-1:0] r_left, w_rd;
  logic [1:0]        w_col, w_row;
  logic              w_cell_zero, w_win_cur, w_open_cur;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .Reset(Reset), .state(w_lfsr));
  assign w_unused_lfsr = ^w_lfsr[15:4];

  assign w_btn   = {up, down, left, right};
  assign w_rise  = w_btn & ~r_btn_prev;
  assign w_press = |w_rise;

  always_comb begin
    w_press_dir = DIR_RIGHT;
    if      (w_rise[3]) w_press_dir = DIR_UP;
    else if (w_rise[2]) w_press_dir = DIR_DOWN;
    else if (w_rise[1]) w_press_dir = DIR_LEFT;
  end

`ifdef PRESS_QUEUE_EN
  logic       r_pend_valid;
  logic [1:0] r_pend_dir;

  always_ff @(posedge Clk) begin
    if (Reset || r_state == ST_WIN || r_state == ST_LOSE) begin
      r_pend_valid <= 1'b0;
      r_pend_dir   <= DIR_UP;
    end else if (r_state == ST_IDLE) begin
      r_pend_valid <= 1'b0;
    end else if (w_press && !r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_dir   <= w_press_dir;
    end
  end

  // A held-over press beats a fresh one arriving in the same idle cycle.
  assign w_launch     = r_pend_valid | w_press;
  assign w_launch_dir = r_pend_valid ? r_pend_dir : w_press_dir;
`else
  assign w_launch     = w_press;
  assign w_launch_dir = w_press_dir;
`endif

  // Adjacency: r_row holds the previous row by column, r_left the cell just read.
  assign w_rd        = lane_bus.cell_rd_data;
  assign w_col       = cell_col(r_chk_idx);
  assign w_row       = cell_row(r_chk_idx);
  assign w_cell_zero = (w_rd == '0);
  assign w_win_cur   = w_rd[TILE_W-1];
  assign w_open_cur  = w_cell_zero
                     || ((w_col != 2'd0) && (w_rd == r_left))
                     || ((w_row != 2'd0) && (w_rd == r_row[w_col]));

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt           = r_state;
    lane_bus.lane_req     = 1'b0;
    lane_bus.cell_rd_addr = 4'd0;
    lane_bus.cell_wr_en   = 1'b0;
    lane_bus.cell_wr_addr = 4'd0;
    lane_bus.cell_wr_data = '0;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_LANE;
      ST_LANE: begin
        lane_bus.lane_req = 1'b1;
        if (lane_bus.lane_ack) begin
          if (r_idx != LAST_LANE)                       w_state_nxt = ST_GAP;
          else if (r_moved_any || lane_bus.lane_moved)  w_state_nxt = ST_SPAWN;
          else                                          w_state_nxt = ST_CHECK;
        end
      end
      ST_GAP: w_state_nxt = ST_LANE;
      ST_SPAWN: begin
        lane_bus.cell_rd_addr = r_scan_addr;
        if (w_cell_zero) begin
          lane_bus.cell_wr_en   = 1'b1;
          lane_bus.cell_wr_addr = r_scan_addr;
          lane_bus.cell_wr_data = TILE_W'(1);
          w_state_nxt           = ST_CHECK;
        end else if (r_scan_cnt == LAST_CELL) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        lane_bus.cell_rd_addr = r_chk_idx;
        if (r_chk_idx == LAST_CELL) begin
          if (r_win || w_win_cur)         w_state_nxt = ST_WIN;
          else if (!(r_open || w_open_cur)) w_state_nxt = ST_LOSE;
          else                            w_state_nxt = ST_IDLE;
        end
      end
      ST_WIN, ST_LOSE: w_state_nxt = r_state;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_btn_prev  <= 4'd0;
      r_dir       <= DIR_UP;
      r_idx       <= 2'd0;
      r_moved_any <= 1'b0;
      r_scan_addr <= 4'd0;
      r_scan_cnt  <= 4'd0;
      r_chk_idx   <= 4'd0;
      r_win       <= 1'b0;
      r_open      <= 1'b0;
      r_left      <= '0;
    end else begin
      r_btn_prev <= w_btn;
      case (r_state)
        ST_IDLE: if (w_launch) begin
          r_dir <= w_launch_dir;
          r_idx <= 2'd0;
        end
        ST_LANE: if (lane_bus.lane_ack) begin
          r_moved_any <= r_moved_any | lane_bus.lane_moved;
          if (r_idx == LAST_LANE) begin
            r_scan_addr <= w_lfsr[3:0];
            r_scan_cnt  <= 4'd0;
            r_chk_idx   <= 4'd0;
            r_win       <= 1'b0;
            r_open      <= 1'b0;
          end
        end
        ST_GAP: r_idx <= r_idx + 2'd1;
        ST_SPAWN: begin
          r_scan_addr <= r_scan_addr + 4'd1;
          r_scan_cnt  <= r_scan_cnt + 4'd1;
        end
        ST_CHECK: begin
          r_chk_idx <= r_chk_idx + 4'd1;
          r_win     <= r_win | w_win_cur;
          r_open    <= r_open | w_open_cur;
          r_left    <= w_rd;
          if (r_chk_idx == LAST_CELL) r_moved_any <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (r_state == ST_CHECK) r_row[w_col] <= w_rd;
  end

  assign lane_bus.lane_dir = r_dir;
  assign lane_bus.lane_idx = r_idx;
  assign busy      = (r_state != ST_IDLE);
  assign game_won  = (r_state == ST_WIN);
  assign game_lost = (r_state == ST_LOSE);
endmodule
`default_nettype wire

// File: tb/tb_move_sequencer_2048.sv
`default_nettype none
// tb_move_sequencer_2048: directed scenarios with a board RAM and lane-unit responder.
`timescale 1ns/1ps
module tb_move_sequencer_2048;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic busy, game_won, game_lost;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [10:0] board [16];
  logic [15:0] m_lfsr;
  int          wr_count = 0;
  logic [3:0]  wr_addr_last = 4'd0;
  logic [10:0] wr_data_last = 11'd0;

  move_sequencer_2048_if #(.TILE_W(11)) bus ();

  move_sequencer_2048 #(.TILE_W(11), .LFSR_SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset(Reset), .up(up), .down(down), .left(left), .right(right),
    .lane_bus(bus), .busy(busy), .game_won(game_won), .game_lost(game_lost)
  );

  always #5 Clk = ~Clk;

  assign bus.cell_rd_data = board[bus.cell_rd_addr];

  always @(posedge Clk) begin
    if (bus.cell_wr_en) begin
      wr_count     <= wr_count + 1;
      wr_addr_last <= bus.cell_wr_addr;
      wr_data_last <= bus.cell_wr_data;
    end
  end

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; {up, down, left, right} = 4'b0;
    bus.lane_ack = 1'b0; bus.lane_moved = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge Clk);
    {up, down, left, right} = b;
  endtask

  // Lane-unit responder: reports what it saw, the calling test judges it.
  task automatic serve_lanes(input logic [3:0] moved, input int delay, input bit wait6,
                             output logic [7:0] idx_seq, output logic [7:0] dir_seq,
                             output bit held_ok, output bit gap_ok, output bit timeout);
    idx_seq = 8'd0; dir_seq = 8'd0; held_ok = 1'b1; gap_ok = 1'b1; timeout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      while (!bus.lane_req && n < 50) begin @(negedge Clk); n++; end
      if (!bus.lane_req) begin timeout = 1'b1; return; end
      idx_seq[i*2 +: 2] = bus.lane_idx;
      dir_seq[i*2 +: 2] = bus.lane_dir;
      n = 0;
      while (n < delay || (wait6 && i == 3 && m_lfsr[3:0] != 4'd6)) begin
        @(negedge Clk); n++;
        if (!bus.lane_req || bus.lane_idx !== idx_seq[i*2 +: 2] || bus.lane_dir !== dir_seq[i*2 +: 2])
          held_ok = 1'b0;
        if (n > 400) begin timeout = 1'b1; return; end
      end
      bus.lane_ack = 1'b1; bus.lane_moved = moved[i];
      @(negedge Clk);
      bus.lane_ack = 1'b0; bus.lane_moved = 1'b0;
      if (bus.lane_req !== 1'b0) gap_ok = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && !game_won && !game_lost && cyc < 100) begin @(negedge Clk); cyc++; end
  endtask

  task automatic test_reset();
    Reset = 1'b1; bus.lane_ack = 1'b0; bus.lane_moved = 1'b0;
    repeat (3) @(negedge Clk);
    tests_run++;
    if ({bus.lane_req, busy, game_won, game_lost, bus.cell_wr_en} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got req/busy/won/lost/wr=%b want 00000",
               {bus.lane_req, busy, game_won, game_lost, bus.cell_wr_en});
    end
    tests_run++;
    if ({bus.lane_dir, bus.lane_idx, bus.cell_rd_addr} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_addr: got dir/idx/rd_addr=%h want 00", {bus.lane_dir, bus.lane_idx, bus.cell_rd_addr});
    end
    tests_run++;
    if (dut.w_lfsr !== 16'hACE1) begin
      tests_failed++; $display("FAIL reset_lfsr: got %h want ace1", dut.w_lfsr);
    end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_no_move();
    logic [7:0] idx_seq, dir_seq; bit held_ok, gap_ok, to; int cyc, wr0;
    for (int i = 0; i < 16; i++) board[i] = 11'd0;
    board[0] = 11'h001;
    wr0 = wr_count;
    press(4'b0010);
    @(negedge Clk);
    tests_run++;
    if (bus.lane_req !== 1'b1 || bus.lane_idx !== 2'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL nomove_first_req: got req=%b idx=%0d busy=%b want 1 0 1", bus.lane_req, bus.lane_idx, busy);
    end
    serve_lanes(4'b0000, 2, 1'b0, idx_seq, dir_seq, held_ok, gap_ok, to);
    tests_run++;
    if (to || idx_seq !== 8'b11_10_01_00 || dir_seq !== 8'b10_10_10_10) begin
      tests_failed++;
      $display("FAIL nomove_lanes: got to=%b idx=%b dir=%b want 0 11100100 10101010", to, idx_seq, dir_seq);
    end
    tests_run++;
    if (!held_ok || !gap_ok) begin
      tests_failed++; $display("FAIL nomove_handshake: got held=%b gap=%b want 1 1", held_ok, gap_ok);
    end
    wait_done(cyc);
    tests_run++;
    if (cyc != 16 || busy !== 1'b0 || wr_count != wr0) begin
      tests_failed++;
      $display("FAIL nomove_check: got cyc=%0d busy=%b writes=%0d want 16 0 0", cyc, busy, wr_count - wr0);
    end
    left = 1'b0;
  endtask

  task automatic test_spawn();
    logic [7:0] idx_seq, dir_seq; bit held_ok, gap_ok, to; int cyc, wr0;
    for (int i = 0; i < 16; i++) board[i] = 11'h002;
    board[5] = 11'd0; board[9] = 11'd0;
    wr0 = wr_count;
    press(4'b0100);
    serve_lanes(4'b0100, 1, 1'b1, idx_seq, dir_seq, held_ok, gap_ok, to);
    tests_run++;
    if (to || dir_seq !== 8'b01_01_01_01) begin
      tests_failed++; $display("FAIL spawn_lanes: got to=%b dir=%b want 0 01010101", to, dir_seq);
    end
    wait_done(cyc);
    tests_run++;
    if (wr_count - wr0 != 1 || wr_addr_last !== 4'd9 || wr_data_last !== 11'h001) begin
      tests_failed++;
      $display("FAIL spawn_write: got n=%0d addr=%0d data=%h want 1 9 001", wr_count - wr0, wr_addr_last, wr_data_last);
    end
    tests_run++;
    if (cyc != 20 || busy !== 1'b0 || game_lost !== 1'b0) begin
      tests_failed++; $display("FAIL spawn_done: got cyc=%0d busy=%b lost=%b want 20 0 0", cyc, busy, game_lost);
    end
    down = 1'b0;
  endtask

  task automatic test_lose();
    logic [7:0] idx_seq, dir_seq; bit held_ok, gap_ok, to, saw; int cyc;
    for (int i = 0; i < 16; i++) board[i] = (((i >> 2) + (i & 3)) % 2 == 1) ? 11'h002 : 11'h001;
    press(4'b1000);
    serve_lanes(4'b0000, 0, 1'b0, idx_seq, dir_seq, held_ok, gap_ok, to);
    wait_done(cyc);
    tests_run++;
    if (to || cyc != 16 || game_lost !== 1'b1 || game_won !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL lose_flag: got to=%b cyc=%0d lost=%b won=%b busy=%b want 0 16 1 0 1", to, cyc, game_lost, game_won, busy);
    end
    up = 1'b0;
    press(4'b0100);
    saw = 1'b0;
    repeat (20) begin @(negedge Clk); if (bus.lane_req) saw = 1'b1; end
    tests_run++;
    if (saw || game_lost !== 1'b1) begin
      tests_failed++; $display("FAIL lose_ignore: got req_seen=%b lost=%b want 0 1", saw, game_lost);
    end
    do_reset();
    tests_run++;
    if (game_lost !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL lose_reset: got lost=%b busy=%b want 0 0", game_lost, busy);
    end
  endtask

  task automatic test_win();
    logic [7:0] idx_seq, dir_seq; bit held_ok, gap_ok, to, saw; int cyc;
    for (int i = 0; i < 16; i++) board[i] = 11'd0;
    board[0] = 11'h001; board[7] = 11'h400;
    press(4'b0001);
    serve_lanes(4'b0000, 1, 1'b0, idx_seq, dir_seq, held_ok, gap_ok, to);
    wait_done(cyc);
    tests_run++;
    if (to || cyc != 16 || game_won !== 1'b1 || game_lost !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL win_flag: got to=%b cyc=%0d won=%b lost=%b busy=%b want 0 16 1 0 1", to, cyc, game_won, game_lost, busy);
    end
    right = 1'b0;
    press(4'b1000);
    saw = 1'b0;
    repeat (20) begin @(negedge Clk); if (bus.lane_req) saw = 1'b1; end
    tests_run++;
    if (saw || game_won !== 1'b1) begin
      tests_failed++; $display("FAIL win_hold: got req_seen=%b won=%b want 0 1", saw, game_won);
    end
    do_reset();
  endtask

  task automatic test_priority_busy();
    logic [7:0] idx_seq, dir_seq; bit held_ok, gap_ok, to, saw; int cyc;
    for (int i = 0; i < 16; i++) board[i] = 11'd0;
    board[0] = 11'h001;
    press(4'b1001);
    @(negedge Clk);
    tests_run++;
    if (bus.lane_req !== 1'b1 || bus.lane_dir !== 2'b00) begin
      tests_failed++; $display("FAIL prio_dir: got req=%b dir=%b want 1 00", bus.lane_req, bus.lane_dir);
    end
    right = 1'b0;
    @(negedge Clk);
    right = 1'b1;
    serve_lanes(4'b0000, 2, 1'b0, idx_seq, dir_seq, held_ok, gap_ok, to);
    tests_run++;
    if (to || dir_seq !== 8'h00 || !held_ok) begin
      tests_failed++; $display("FAIL busy_dir_held: got to=%b dir=%b held=%b want 0 00000000 1", to, dir_seq, held_ok);
    end
    wait_done(cyc);
`ifdef PRESS_QUEUE_EN
    @(negedge Clk);
    tests_run++;
    if (bus.lane_req !== 1'b1 || bus.lane_dir !== 2'b11 || bus.lane_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL queue_replay: got req=%b dir=%b idx=%0d want 1 11 0", bus.lane_req, bus.lane_dir, bus.lane_idx);
    end
    serve_lanes(4'b0000, 0, 1'b0, idx_seq, dir_seq, held_ok, gap_ok, to);
    wait_done(cyc);
    tests_run++;
    if (to || dir_seq !== 8'hFF || busy !== 1'b0) begin
      tests_failed++; $display("FAIL queue_run: got to=%b dir=%b busy=%b want 0 11111111 0", to, dir_seq, busy);
    end
`else
    saw = 1'b0;
    repeat (20) begin @(negedge Clk); if (bus.lane_req) saw = 1'b1; end
    tests_run++;
    if (saw || busy !== 1'b0) begin
      tests_failed++; $display("FAIL busy_drop: got req_seen=%b busy=%b want 0 0", saw, busy);
    end
`endif
    {up, down, left, right} = 4'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    press(4'b0010);
    @(negedge Clk);
    tests_run++;
    if (bus.lane_req !== 1'b1) begin
      tests_failed++; $display("FAIL mid_req: got req=%b want 1", bus.lane_req);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1; left = 1'b0;
    @(negedge Clk);
    tests_run++;
    if (bus.lane_req !== 1'b0 || busy !== 1'b0 || dut.w_lfsr !== 16'hACE1) begin
      tests_failed++;
      $display("FAIL mid_reset: got req=%b busy=%b lfsr=%h want 0 0 ace1", bus.lane_req, busy, dut.w_lfsr);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if (bus.lane_req !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_after: got req=%b busy=%b want 0 0", bus.lane_req, busy);
    end
  endtask

  initial begin
    test_reset();
    test_no_move();
    test_spawn();
    test_lose();
    test_win();
    test_priority_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
